// File: rtl/ucie_ctl_rx_pkg.sv
// Shared encodings for the RX buffer controller: RDI status codes and
// controller states.
package ucie_ctl_rx_pkg;

  localparam logic [3:0] ST_RESET     = 4'b0000;
  localparam logic [3:0] ST_ACTIVE    = 4'b0001;
  localparam logic [3:0] ST_LINKRESET = 4'b1001;
  localparam logic [3:0] ST_LINKERROR = 4'b1010;
  localparam logic [3:0] ST_RETRAIN   = 4'b1011;
  localparam logic [3:0] ST_DISABLED  = 4'b1100;

  typedef enum logic [2:0] {
    CTL_IDLE   = 3'd0,
    CTL_ARM    = 3'd1,
    CTL_ACTIVE = 3'd2,
    CTL_DRAIN  = 3'd3,
    CTL_HOLD   = 3'd4,
    CTL_ERROR  = 3'd5
  } ctl_state_e;

  // Status codes outside this set (L1, L2, ...) are ignored except in ACTIVE.
  function automatic logic is_listed(input logic [3:0] sts);
    return sts inside {ST_RESET, ST_ACTIVE, ST_LINKRESET, ST_LINKERROR,
                       ST_RETRAIN, ST_DISABLED};
  endfunction

endpackage

// File: rtl/ucie_ctl_rx_occ_tracker.sv
// Saturating up/down shadow count of flits held in the RX buffer.
module ucie_ctl_rx_occ_tracker #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] occ
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic push_ok;
  logic pop_ok;

  assign push_ok = push && (occ < OCC_W'(DEPTH));
  assign pop_ok  = pop && (occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (clr) begin
      occ <= '0;
    end else if (push_ok && !pop_ok) begin
      occ <= occ + 1'b1;
    end else if (pop_ok && !push_ok) begin
      occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/ucie_ctl_rx_buffer_ctrl.sv
// RX flit buffer sequencing controller (enable, shadow occupancy, drain, error).
// Optional statistics counters are built when UCIE_CTL_RX_BUF_STATS_EN is defined.
module ucie_ctl_rx_buffer_ctrl
  import ucie_ctl_rx_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int EN_DLY        = 2,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_pl_state_sts,
  input  logic                   i_rdi_pl_valid,
  input  logic                   i_fdi_data_valid,
  input  logic                   i_overflow_detected,
  output logic                   o_buffer_en,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic                   o_drain_done,
  output logic                   o_lp_linkerror,
  output logic [2:0]             o_fsm_state,
  output logic [15:0]            o_rx_flit_cnt,
  output logic [7:0]             o_ovf_evt_cnt
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int ARM_W = $clog2(EN_DLY + 1);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  ctl_state_e       state;
  ctl_state_e       state_next;
  logic [ARM_W-1:0] arm_cnt;
  logic [TMR_W-1:0] drain_tmr;
  logic             occ_clr;

  always_comb begin
    state_next = state;
    case (state)
      CTL_IDLE:
        if (i_pl_state_sts == ST_ACTIVE) state_next = CTL_ARM;
      CTL_ARM:
        if (i_pl_state_sts == ST_ACTIVE) begin
          if (arm_cnt == ARM_W'(EN_DLY - 1)) state_next = CTL_ACTIVE;
        end else if (is_listed(i_pl_state_sts)) begin
          state_next = CTL_IDLE;
        end
      CTL_ACTIVE:
        case (i_pl_state_sts)
          ST_ACTIVE:             state_next = CTL_ACTIVE;
          ST_RESET, ST_DISABLED: state_next = CTL_IDLE;
          ST_LINKERROR:          state_next = CTL_ERROR;
          default:               state_next = CTL_DRAIN;
        endcase
      CTL_DRAIN:
        // New flits arriving while draining mean the PHY side ignored the exit.
        if (i_rdi_pl_valid) state_next = CTL_ERROR;
        else if (o_occupancy == '0) state_next = CTL_HOLD;
        else if (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1)) state_next = CTL_ERROR;
      CTL_HOLD:
        if (i_pl_state_sts == ST_ACTIVE) state_next = CTL_ARM;
        else if (i_pl_state_sts == ST_RESET || i_pl_state_sts == ST_DISABLED)
          state_next = CTL_IDLE;
      CTL_ERROR:
        if (i_pl_state_sts == ST_RESET) state_next = CTL_IDLE;
      default:
        state_next = CTL_IDLE;
    endcase
    if (i_overflow_detected) state_next = CTL_ERROR;
  end

  assign occ_clr = (state_next == CTL_IDLE) && (state != CTL_IDLE);

  ucie_ctl_rx_occ_tracker #(.DEPTH(DEPTH)) u_occ (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clr   (occ_clr),
    .push  (i_rdi_pl_valid & o_buffer_en),
    .pop   (i_fdi_data_valid),
    .occ   (o_occupancy)
  );

  // Outputs are registered from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= CTL_IDLE;
      arm_cnt        <= '0;
      drain_tmr      <= '0;
      o_buffer_en    <= 1'b0;
      o_drain_done   <= 1'b0;
      o_lp_linkerror <= 1'b0;
    end else begin
      state          <= state_next;
      o_buffer_en    <= (state_next == CTL_ACTIVE) || (state_next == CTL_DRAIN);
      o_drain_done   <= (state == CTL_DRAIN) && (state_next == CTL_HOLD);
      o_lp_linkerror <= (state_next == CTL_ERROR);
      if (state_next == CTL_ARM && state != CTL_ARM) arm_cnt <= '0;
      else if (state == CTL_ARM && i_pl_state_sts == ST_ACTIVE) arm_cnt <= arm_cnt + 1'b1;
      if (state_next == CTL_DRAIN && state != CTL_DRAIN) drain_tmr <= '0;
      else if (state == CTL_DRAIN) drain_tmr <= drain_tmr + 1'b1;
    end
  end

  assign o_fsm_state = state;

`ifdef UCIE_CTL_RX_BUF_STATS_EN
  logic flit_acc;
  logic err_entry;

  assign flit_acc  = i_rdi_pl_valid & o_buffer_en & (o_occupancy < OCC_W'(DEPTH));
  assign err_entry = (state_next == CTL_ERROR) && (state != CTL_ERROR);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rx_flit_cnt <= '0;
      o_ovf_evt_cnt <= '0;
    end else begin
      if (flit_acc && o_rx_flit_cnt != 16'hFFFF) o_rx_flit_cnt <= o_rx_flit_cnt + 1'b1;
      if (err_entry && o_ovf_evt_cnt != 8'hFF) o_ovf_evt_cnt <= o_ovf_evt_cnt + 1'b1;
    end
  end
`else
  assign o_rx_flit_cnt = '0;
  assign o_ovf_evt_cnt = '0;
`endif

endmodule

// File: doc/ucie_ctl_rx_buffer_ctrl.md
Name: ucie_ctl_rx_buffer_ctrl

Overview:
Sequencing controller for the RX flit buffer between RDI (PHY side) and FDI (protocol side).
- Drives the buffer enable from the RDI link state.
- Keeps a shadow occupancy count.
- Drains the buffer when the link leaves Active.
- Escalates buffer overflow or a drain timeout to a LinkError request.
- Sits beside the buffer in the RX path and is controlled by the top-level controller FSM.

Parameters:
DEPTH, 4, buffer depth in flits; must match the buffer instance.
EN_DLY, 2, consecutive Active-status cycles required before the buffer is enabled.
DRAIN_TIMEOUT, 16, maximum cycles allowed in DRAIN before an error is declared.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-low
i_pl_state_sts  in  4  RDI state: 0000 Reset, 0001 Active, 1001 LinkReset, 1010 LinkError, 1011 Retrain, 1100 Disabled
i_rdi_pl_valid  in  1  flit presented to the buffer
i_fdi_data_valid  in  1  flit emitted by the buffer
i_overflow_detected  in  1  sticky overflow flag from the buffer
o_buffer_en  out  1  buffer enable
o_occupancy  out  $clog2(DEPTH)+1  shadow flit count
o_drain_done  out  1  one-cycle pulse when DRAIN completes with the buffer empty
o_lp_linkerror  out  1  LinkError request to the adapter FSM
o_fsm_state  out  3  current state encoding
o_rx_flit_cnt  out  16  statistics (see Optional Feature)
o_ovf_evt_cnt  out  8  statistics (see Optional Feature)

Behaviour:
Reset:
- Asynchronous on i_rst low.
- All outputs 0, state IDLE, all counters 0.

State encoding: IDLE=0, ARM=1, ACTIVE=2, DRAIN=3, HOLD=4, ERROR=5.

Transition priority: ERROR entry beats every other transition.

Registered outputs: all outputs are registered; o_buffer_en reflects the state entered, one cycle after the decision.

States and transitions:
- IDLE: o_buffer_en=0. Status==Active → ARM, with the arm counter cleared.
- ARM: o_buffer_en=0.
  - Arm counter increments while status==Active.
  - Any other status → IDLE.
  - Counter reaching EN_DLY-1 → ACTIVE.
  - With EN_DLY=1, ACTIVE is entered on the cycle after ARM is entered.
- ACTIVE: o_buffer_en=1.
  - Status Retrain or LinkReset → DRAIN, with the drain timer cleared.
  - Status Reset or Disabled → IDLE.
  - Status LinkError → ERROR.
- DRAIN: o_buffer_en=1 so the read side keeps emptying.
  - Occupancy==0 → HOLD, with o_drain_done pulsed for one cycle on entry to HOLD.
  - Timer reaching DRAIN_TIMEOUT-1 with occupancy>0 → ERROR.
  - Any i_rdi_pl_valid while in DRAIN is a protocol violation → ERROR.
- HOLD: o_buffer_en=0.
  - Status==Active → ARM.
  - Status Reset or Disabled → IDLE.
- ERROR: o_buffer_en=0, o_lp_linkerror=1.
  - Both are held until status==Reset, then → IDLE and o_lp_linkerror clears.
- Any state: i_overflow_detected=1 → ERROR on the next edge.

Occupancy:
- inc = i_rdi_pl_valid & o_buffer_en & (occ<DEPTH).
- dec = i_fdi_data_valid & (occ>0).
- inc and dec together: no change.
- Saturates at 0 and at DEPTH; never wraps.
- Cleared on entry to IDLE.
- Not cleared on entry to ERROR, so the value remains visible for debug.

Status decoding: unlisted status encodings (L1, L2) are treated like Retrain while in ACTIVE and are ignored in every other state.

Optional Feature:
Macro UCIE_CTL_RX_BUF_STATS_EN.
- Defined:
  - o_rx_flit_cnt increments on each inc; 16-bit, saturates at 0xFFFF.
  - o_ovf_evt_cnt increments on each ERROR entry; 8-bit, saturates at 0xFF.
  - Both counters clear only on reset.
- Undefined: both ports are still present, tied to 0, with no counter flops.

Decomposition:
- Package ucie_ctl_rx_pkg: RDI state localparams (ST_RESET, ST_ACTIVE, ST_LINKRESET, ST_LINKERROR, ST_RETRAIN, ST_DISABLED) and the controller state localparams.
- Sub-module ucie_ctl_rx_occ_tracker: saturating up/down occupancy counter with parameter DEPTH and a clear input.

Test Plan:
- Reset, then status=0001 held with EN_DLY=2 → o_buffer_en rises 3 cycles after status asserts; o_fsm_state goes 1 then 2.
- In ACTIVE, 3 rdi_pl_valid pulses then 1 fdi_data_valid → o_occupancy=2. Simultaneous inc/dec → count unchanged. 5 pushes with DEPTH=4 and no pops → saturates at 4.
- Occupancy=2, status→1011, two fdi_data_valid → HOLD after occupancy reaches 0, single o_drain_done pulse, o_buffer_en=0. Status→0001 → re-ARM.
- DRAIN with occupancy stuck at 1 for 16 cycles → ERROR and o_lp_linkerror=1. Holds until status=0000, then IDLE with o_occupancy=0.
- i_overflow_detected pulsed in ACTIVE → ERROR next cycle. With the stats macro defined, o_ovf_evt_cnt=1 and o_rx_flit_cnt equals the number of accepted flits.
- i_rst deasserted-to-asserted mid-DRAIN → all outputs 0 immediately (asynchronous), state IDLE.
